instr_word_buffer: RTL and testbench
====================================

// Module: instr_word_buffer
// PURPOSE
//  Parametrised successor to the UART instruction loader. Assembles the serial
//  bit stream from the UART receiver (one symbol per rx_done_tick) into
//  WORD_W-bit instruction words and queues them in a DEPTH-entry circular FIFO.
//  The FIFO drains to the valve/flow sequencer over a valid/ready handshake.
//  Adds status flags: count, full, empty, sticky overflow.
// PARAMETERS
//  WORD_W     13    instruction word width, in bits (>=2)
//  DEPTH      100   FIFO entries (any value >=2; power of two not required)
//  CNT_W      7     pointer width; must satisfy 2**CNT_W >= DEPTH
//  LSB_FIRST  1     1: first received bit -> word[0]; 0: first bit -> word[WORD_W-1]
// PORTS
//  clk           in   1       system clock
//  rst           in   1       asynchronous, active-high reset
//  rx_done_tick  in   1       one-cycle strobe: atob carries a valid symbol
//  atob          in   2       symbol: 0/1 = data bit, 2 = resync, 3 = ignored
//  instr_out     out  WORD_W  head-of-FIFO word; valid only while instr_valid=1
//  instr_valid   out  1       FIFO not empty
//  instr_ready   in   1       consumer accepts instr_out when valid&ready
//  count         out  CNT_W+1 words held, 0..DEPTH
//  full          out  1       count==DEPTH
//  empty         out  1       count==0
//  overflow      out  1       sticky: a completed word was dropped because FIFO full
//  parity_err    out  1       sticky parity failure; tied 0 without INSTR_BUF_PARITY_EN
//  clr_flags     in   1       sync clear of overflow and parity_err
// BEHAVIOUR
//  - Reset (async assert, sync-to-clk deassert by top level) clears: bit counter,
//    shift register, rd/wr pointers, count=0, empty=1, full=0, instr_valid=0,
//    overflow=0, parity_err=0. instr_out reads 0 while empty.
//    Storage array is not cleared.
//  - Assembler FSM states:
//    COLLECT: on tick with atob<2, shift the bit in per LSB_FIRST, bitcnt+1.
//             After the WORD_W-th bit -> COMMIT (or PARITY when the macro is set).
//    PARITY:  the next data tick carries the parity bit -> COMMIT or DROP.
//    COMMIT:  one cycle; push the word if !full or pop occurs in the same cycle.
//             Otherwise drop the word and set overflow. Then return to COLLECT
//             with bitcnt=0.
//    DROP:    one cycle; discard the word, set parity_err, return to COLLECT.
//  - atob==2 on a tick, in any state: discard the partial word, bitcnt=0, go to
//    COLLECT. A word already in COMMIT still completes; resync applies afterwards.
//  - atob==3, or no tick: no effect.
//  - Latency: the word appears at instr_out and instr_valid rises 2 cycles after
//    the tick carrying its last bit (COMMIT cycle + register update).
//  - Pop: on instr_valid&instr_ready, rd_ptr advances at the next edge.
//    instr_out is a combinational read of mem[rd_ptr].
//  - Simultaneous push and pop: both occur and count is unchanged. This holds
//    when full (the push succeeds, no overflow) and when count==1.
//  - Pointer wrap: DEPTH-1 -> 0, explicit compare. No modulo-2**CNT_W wrap.
//  - instr_ready while empty: ignored; pointers and count do not move.
//  - clr_flags coinciding with a new overflow/parity event: the set wins.
//  - Reset mid-word or mid-COMMIT: the partial word is lost and no push occurs.
// CONFIGURATION
//  INSTR_BUF_PARITY_EN defined:
//    - each word is followed by one even-parity bit, covering the WORD_W data bits.
//    - match -> COMMIT; mismatch -> DROP (word discarded, parity_err=1).
//  INSTR_BUF_PARITY_EN undefined:
//    - no PARITY/DROP states; a word commits right after its WORD_W-th bit.
//    - parity_err is constant 0.
// TESTING
//  1. Reset, then 13 ticks of bits 1,0,1,1,0,0,0,0,0,0,0,0,1 (LSB_FIRST=1)
//     -> instr_out=13'h100D, count=1, instr_valid=1 two cycles after the last tick.
//  2. 5 bits, then atob=2, then 13 bits of 13'h0AAA -> only 13'h0AAA is queued,
//     count=1.
//  3. Fill 100 words (values 0..99), then send a 101st -> full=1, overflow=1,
//     count=100. Drain all 100 with ready held high -> values 0..99 in order,
//     empty=1, wrap exercised.
//  4. With full=1, hold ready=1 through the 101st word's COMMIT cycle -> push
//     accepted, count stays 100, overflow stays 0.
//  5. rst pulse mid-word (after 7 bits) with 3 words queued -> count=0, empty=1;
//     the next 13 bits form a clean first word.
//  6. With INSTR_BUF_PARITY_EN: word 13'h0003 + parity 1 -> dropped, parity_err=1;
//     same word + parity 0 -> queued. clr_flags -> parity_err=0.

Source files
------------

// File: rtl/instr_word_buffer_if.sv
// Interface bundling the symbol input, the valid/ready drain port and the
// status/flag signals of instr_word_buffer.
//   master : the environment (UART receiver, sequencer, status reader)
//   slave  : the buffer itself
interface instr_word_buffer_if #(
  parameter int WORD_W = 13,
  parameter int CNT_W  = 7
);
  logic              rx_done_tick;
  logic [1:0]        atob;
  logic [WORD_W-1:0] instr_out;
  logic              instr_valid;
  logic              instr_ready;
  logic [CNT_W:0]    count;
  logic              full;
  logic              empty;
  logic              overflow;
  logic              parity_err;
  logic              clr_flags;

  modport master (
    output rx_done_tick, atob, instr_ready, clr_flags,
    input  instr_out, instr_valid, count, full, empty, overflow, parity_err
  );

  modport slave (
    input  rx_done_tick, atob, instr_ready, clr_flags,
    output instr_out, instr_valid, count, full, empty, overflow, parity_err
  );
endinterface

// File: rtl/instr_word_buffer.sv
// instr_word_buffer: assembles serial bit symbols into WORD_W-bit instruction
// words and queues them in a DEPTH-entry circular FIFO drained over valid/ready.
// Optional feature macro: INSTR_BUF_PARITY_EN (one even-parity bit per word;
// mismatching words are dropped and flagged on parity_err).
module instr_word_buffer #(
  parameter int WORD_W    = 13,
  parameter int DEPTH     = 100,
  parameter int CNT_W     = 7,
  parameter int LSB_FIRST = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  instr_word_buffer_if.slave   bus
);
  localparam int BC_W = $clog2(WORD_W + 1);
  localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] LAST_PTR = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W:0]   DEPTH_C  = (CNT_W + 1)'(DEPTH);

`ifdef INSTR_BUF_PARITY_EN
  typedef enum logic [1:0] {ST_COLLECT = 2'd0, ST_COMMIT = 2'd1,
                            ST_PARITY  = 2'd2, ST_DROP   = 2'd3} state_e;

  // Even parity over the data bits: the expected parity bit value.
  function automatic logic even_parity(input logic [WORD_W-1:0] w);
    return ^w;
  endfunction
`else
  typedef enum logic [1:0] {ST_COLLECT = 2'd0, ST_COMMIT = 2'd1} state_e;
`endif

  // Insert one received bit into the partial word according to bit order.
  function automatic logic [WORD_W-1:0] shift_in(input logic [WORD_W-1:0] w,
                                                  input logic b);
    if (LSB_FIRST != 0) return {b, w[WORD_W-1:1]};
    else                return {w[WORD_W-2:0], b};
  endfunction

  state_e            state_q, state_d;
  logic [BC_W-1:0]   bitcnt_q, bitcnt_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W:0]    count_q, count_d;
  logic              full_q, empty_q, overflow_q;
  logic [WORD_W-1:0] mem_q [DEPTH];
  logic              data_tick_s, resync_s, commit_s, drop_s;
  logic              push_s, pop_s, ovf_set_s;

  assign data_tick_s = bus.rx_done_tick & ~bus.atob[1];
  assign resync_s    = bus.rx_done_tick & (bus.atob == 2'd2);

  // Assembler next-state: collect bits, optionally check parity, then commit.
  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    commit_s = 1'b0;
    drop_s   = 1'b0;
    case (state_q)
      ST_COLLECT: begin
        if (resync_s) begin
          bitcnt_d = {BC_W{1'b0}};
        end else if (data_tick_s) begin
          shift_d = shift_in(shift_q, bus.atob[0]);
          if (bitcnt_q == LAST_BIT) begin
            bitcnt_d = {BC_W{1'b0}};
`ifdef INSTR_BUF_PARITY_EN
            state_d  = ST_PARITY;
`else
            state_d  = ST_COMMIT;
`endif
          end else begin
            bitcnt_d = bitcnt_q + BC_W'(1);
          end
        end else begin
          state_d = ST_COLLECT;
        end
      end
      // The completed word is pushed this cycle; any tick now is not sampled.
      ST_COMMIT: begin
        commit_s = 1'b1;
        bitcnt_d = {BC_W{1'b0}};
        state_d  = ST_COLLECT;
      end
`ifdef INSTR_BUF_PARITY_EN
      ST_PARITY: begin
        if (resync_s) begin
          state_d = ST_COLLECT;
        end else if (data_tick_s) begin
          state_d = (bus.atob[0] == even_parity(shift_q)) ? ST_COMMIT : ST_DROP;
        end else begin
          state_d = ST_PARITY;
        end
      end
      ST_DROP: begin
        drop_s   = 1'b1;
        bitcnt_d = {BC_W{1'b0}};
        state_d  = ST_COLLECT;
      end
`endif
      default: begin
        bitcnt_d = {BC_W{1'b0}};
        state_d  = ST_COLLECT;
      end
    endcase
  end

  // Assembler state, bit counter and shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_COLLECT;
      bitcnt_q <= {BC_W{1'b0}};
      shift_q  <= {WORD_W{1'b0}};
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
    end
  end

  // A full FIFO still accepts the word when a pop frees a slot in the same cycle.
  assign pop_s     = ~empty_q & bus.instr_ready;
  assign push_s    = commit_s & (~full_q | pop_s);
  assign ovf_set_s = commit_s & full_q & ~pop_s;

  // Occupancy update from push/pop.
  always_comb begin
    count_d = count_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + (CNT_W + 1)'(1);
      2'b01:   count_d = count_q - (CNT_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO pointers, occupancy and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= {CNT_W{1'b0}};
      rd_ptr_q   <= {CNT_W{1'b0}};
      count_q    <= {(CNT_W + 1){1'b0}};
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      if (push_s) wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? {CNT_W{1'b0}} : wr_ptr_q + CNT_W'(1);
      if (pop_s)  rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? {CNT_W{1'b0}} : rd_ptr_q + CNT_W'(1);
      count_q    <= count_d;
      full_q     <= (count_d == DEPTH_C);
      empty_q    <= (count_d == {(CNT_W + 1){1'b0}});
      overflow_q <= ovf_set_s | (overflow_q & ~bus.clr_flags);
    end
  end

  // Word storage; intentionally not cleared by reset.
  always_ff @(posedge clk) begin
    if (push_s) mem_q[wr_ptr_q] <= shift_q;
  end

`ifdef INSTR_BUF_PARITY_EN
  logic parity_err_q;

  // Sticky parity error; a new failure wins over a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) parity_err_q <= 1'b0;
    else     parity_err_q <= drop_s | (parity_err_q & ~bus.clr_flags);
  end

  assign bus.parity_err = parity_err_q;
`else
  assign bus.parity_err = 1'b0;
`endif

  assign bus.instr_out   = empty_q ? {WORD_W{1'b0}} : mem_q[rd_ptr_q];
  assign bus.instr_valid = ~empty_q;
  assign bus.count       = count_q;
  assign bus.full        = full_q;
  assign bus.empty       = empty_q;
  assign bus.overflow    = overflow_q;
endmodule

// File: tb/tb_instr_word_buffer.sv
// Directed, scoreboard-based bench for instr_word_buffer.
module tb_instr_word_buffer;
  localparam int WORD_W = 13;
  localparam int DEPTH  = 100;
  localparam int CNT_W  = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests_run = 0;
  int   tests_failed = 0;
  logic [WORD_W-1:0] sb [$];

  always #5 clk = ~clk;

  instr_word_buffer_if #(.WORD_W(WORD_W), .CNT_W(CNT_W)) bus ();

  instr_word_buffer #(.WORD_W(WORD_W), .DEPTH(DEPTH), .CNT_W(CNT_W), .LSB_FIRST(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One symbol tick; entered and left on a falling edge.
  task automatic send_sym(input logic [1:0] s);
    bus.rx_done_tick = 1'b1;
    bus.atob = s;
    @(negedge clk);
    bus.rx_done_tick = 1'b0;
    bus.atob = 2'd3;
  endtask

  task automatic send_bits(input logic [WORD_W-1:0] w, input int n);
    for (int i = 0; i < n; i++) send_sym({1'b0, w[i]});
  endtask

  task automatic send_tail(input logic [WORD_W-1:0] w);
`ifdef INSTR_BUF_PARITY_EN
    send_sym({1'b0, ^w});
`endif
  endtask

  // Full word (plus parity); returns once the COMMIT cycle has completed.
  task automatic send_word(input logic [WORD_W-1:0] w, input bit exp_push, input bit pop_in_commit);
    send_bits(w, WORD_W);
    send_tail(w);
    if (pop_in_commit) begin
      check("head_before_pop", 32'(bus.instr_out), 32'(sb.pop_front()));
      bus.instr_ready = 1'b1;
    end
    if (exp_push) sb.push_back(w);
    @(negedge clk);
    bus.instr_ready = 1'b0;
  endtask

  // Pop n words with ready held high, comparing each against the scoreboard.
  task automatic drain(input int n);
    logic [WORD_W-1:0] exp_w;
    bus.instr_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      exp_w = (sb.size() > 0) ? sb.pop_front() : {WORD_W{1'b0}};
      check("drain_valid", 32'(bus.instr_valid), 32'd1);
      check("drain_data", 32'(bus.instr_out), 32'(exp_w));
      @(negedge clk);
    end
    bus.instr_ready = 1'b0;
    check("drain_empty", 32'(bus.empty), 32'd1);
  endtask

  initial begin
    logic [WORD_W-1:0] w;
    bus.rx_done_tick = 1'b0;
    bus.atob = 2'd3;
    bus.instr_ready = 1'b0;
    bus.clr_flags = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_empty", 32'(bus.empty), 32'd1);
    check("rst_full", 32'(bus.full), 32'd0);
    check("rst_valid", 32'(bus.instr_valid), 32'd0);
    check("rst_overflow", 32'(bus.overflow), 32'd0);
    check("rst_parity_err", 32'(bus.parity_err), 32'd0);
    check("rst_instr_out", 32'(bus.instr_out), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Ready while empty is ignored
    bus.instr_ready = 1'b1;
    repeat (2) @(negedge clk);
    bus.instr_ready = 1'b0;
    check("rdy_empty_count", 32'(bus.count), 32'd0);
    check("rdy_empty_empty", 32'(bus.empty), 32'd1);

    // Test 1: bits 1,0,1,1,0..0,1 -> 13'h100D, two cycles of latency
    w = 13'h100D;
    send_bits(w, WORD_W);
    send_tail(w);
    check("t1_valid_early", 32'(bus.instr_valid), 32'd0);
    @(negedge clk);
    check("t1_valid", 32'(bus.instr_valid), 32'd1);
    check("t1_out", 32'(bus.instr_out), 32'h100D);
    check("t1_count", 32'(bus.count), 32'd1);
    sb.push_back(w);
    drain(1);

    // Test 2: partial word, resync, then 13'h0AAA with an ignored symbol inside
    send_bits(13'h1F, 5);
    send_sym(2'd2);
    w = 13'h0AAA;
    for (int i = 0; i < WORD_W; i++) begin
      if (i == 6) send_sym(2'd3);
      send_sym({1'b0, w[i]});
    end
    send_tail(w);
    @(negedge clk);
    check("t2_count", 32'(bus.count), 32'd1);
    sb.push_back(w);
    drain(1);

    // Test 3: fill, overflow, drain in order across the pointer wrap
    for (int v = 0; v < DEPTH; v++) send_word(13'(v), 1'b1, 1'b0);
    check("t3_full", 32'(bus.full), 32'd1);
    check("t3_count_full", 32'(bus.count), 32'(DEPTH));
    check("t3_no_ovf_yet", 32'(bus.overflow), 32'd0);
    send_word(13'd100, 1'b0, 1'b0);
    check("t3_overflow", 32'(bus.overflow), 32'd1);
    check("t3_count_ovf", 32'(bus.count), 32'(DEPTH));
    drain(DEPTH);
    check("t3_count_drained", 32'(bus.count), 32'd0);
    check("t3_overflow_sticky", 32'(bus.overflow), 32'd1);
    bus.clr_flags = 1'b1;
    @(negedge clk);
    bus.clr_flags = 1'b0;
    check("clr_overflow", 32'(bus.overflow), 32'd0);

    // Test 4: push accepted while full because a pop happens in the COMMIT cycle
    for (int v = 0; v < DEPTH; v++) send_word(13'(200 + v), 1'b1, 1'b0);
    send_word(13'd777, 1'b1, 1'b1);
    check("t4_count", 32'(bus.count), 32'(DEPTH));
    check("t4_full", 32'(bus.full), 32'd1);
    check("t4_overflow", 32'(bus.overflow), 32'd0);
    drain(DEPTH);

    // Test 5: reset mid-word with three words queued
    for (int v = 0; v < 3; v++) send_word(13'(50 + v), 1'b1, 1'b0);
    check("t5_count3", 32'(bus.count), 32'd3);
    send_bits(13'h1FFF, 7);
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_count", 32'(bus.count), 32'd0);
    check("t5_rst_empty", 32'(bus.empty), 32'd1);
    check("t5_rst_valid", 32'(bus.instr_valid), 32'd0);
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    send_word(13'h1234, 1'b1, 1'b0);
    check("t5_count1", 32'(bus.count), 32'd1);
    drain(1);

`ifdef INSTR_BUF_PARITY_EN
    // Test 6: bad parity drops the word, good parity queues it, clear works
    send_bits(13'h0003, WORD_W);
    send_sym(2'd1);
    repeat (2) @(negedge clk);
    check("t6_parity_err", 32'(bus.parity_err), 32'd1);
    check("t6_dropped", 32'(bus.count), 32'd0);
    send_word(13'h0003, 1'b1, 1'b0);
    check("t6_queued", 32'(bus.count), 32'd1);
    bus.clr_flags = 1'b1;
    @(negedge clk);
    bus.clr_flags = 1'b0;
    check("t6_clr", 32'(bus.parity_err), 32'd0);
    drain(1);
`else
    check("parity_err_tied", 32'(bus.parity_err), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
